branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Direct-mapped branch target buffer (BTB) with 2-bit saturating counters, sitting in IF.
//  Supplies predict_taken / predict_target for the fetch PC; the prediction bit travels down the
//  pipeline as the branch unit's branchPrediction input.
//  Trained from the resolution point with the actual outcome and the branch unit's branch_pc as target.
//  Also counts mispredictions for performance measurement.
// PARAMETERS
//  DATA_W  16  PC / target width in bits
//  IDX_W   4   index bits; table holds 2**IDX_W entries; TAG_W = DATA_W-IDX_W-2
// PORTS
//  clk              in   1       rising-edge clock
//  arst_n           in   1       asynchronous reset, active low
//  lookup_pc        in   DATA_W  PC currently being fetched
//  predict_taken    out  1       1 = predict taken
//  predict_target   out  DATA_W  next-PC prediction
//  update_en        in   1       1 = a branch resolved this cycle; train the table
//  update_pc        in   DATA_W  PC of the resolved branch
//  update_taken     in   1       actual outcome of the resolved branch
//  update_target    in   DATA_W  taken-path target of the resolved branch (branch_pc)
//  mispredict       in   1       resolved branch was mispredicted; sampled only when update_en=1
//  mispredict_count out  16      saturating misprediction count
// BEHAVIOUR
//  Entry fields: valid(1), tag(TAG_W), target(DATA_W), ctr(2).
//   - index = pc[IDX_W+1:2]; tag = pc[DATA_W-1:IDX_W+2]; pc[1:0] are ignored.
//  Lookup is purely combinational from the registered table (0-cycle latency):
//   - hit = valid[idx] & (tag[idx]==lookup tag).
//   - predict_taken = hit & ctr[idx][1].
//   - predict_target = predict_taken ? target[idx] : lookup_pc + 4, modulo 2**DATA_W
//     (wrap-around: 0xFFFC -> 0x0000).
//  Counter FSM per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//   - taken: +1, saturating at 11.
//   - not-taken: -1, saturating at 00.
//  Update happens on the rising edge of clk when update_en=1:
//   - hit + taken: ctr increments; target <= update_target.
//   - hit + not-taken: ctr decrements; target is kept.
//   - miss + taken: allocate/replace the entry: valid=1, tag written, target written, ctr=10.
//   - miss + not-taken: no change (no allocation).
//   - update_en=0: table is unchanged; mispredict is ignored.
//  Simultaneous lookup and update of the same entry: lookup returns the pre-update state
//  (no bypass); the new state is visible from the next cycle.
//  mispredict_count increments on each edge with update_en & mispredict; it holds at 16'hFFFF.
//  Reset (arst_n=0, asynchronous, also mid-operation):
//   - all valid <= 0, all ctr <= 00, tags/targets <= 0, mispredict_count <= 0 immediately.
//   - predict_taken therefore reads 0 and predict_target reads lookup_pc+4 while reset is held
//     and after reset.
//   - no update is taken while arst_n=0.
// TESTING
//  1. Reset, lookup_pc=0x0040 -> predict_taken=0, predict_target=0x0044, mispredict_count=0.
//  2. Update pc=0x0040, taken=1, target=0x0020, mispredict=1; next cycle lookup 0x0040
//     -> taken=1, target=0x0020, count=1.
//  3. From (2), two not-taken updates of 0x0040 -> ctr 10->01->00; predict_taken=0 after the
//     first update; target stays 0x0020.
//  4. Aliasing (IDX_W=4): 0x0040 allocated; lookup 0x0080 (same index, different tag)
//     -> taken=0, target 0x0084; taken update of 0x0080 replaces the entry, after which 0x0040 misses.
//  5. Same-cycle lookup and update of a fresh pc 0x0010 (taken) -> predict_taken=0 that cycle,
//     predict_taken=1 the next cycle; lookup 0xFFFC on a miss -> predict_target=0x0000.
//  6. Pull arst_n low between clock edges after steps 2-4 -> all lookups miss immediately and
//     count=0; a 0x10000-th mispredict leaves the count at 0xFFFF.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit saturating direction counters
//               and a saturating misprediction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              predict_taken,
    output logic [DATA_W-1:0] predict_target,
    input  logic              update_en,
    input  logic [DATA_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [DATA_W-1:0] update_target,
    input  logic              mispredict,
    output logic [15:0]       mispredict_count
);

    localparam int TAG_W   = DATA_W - IDX_W - 2;
    localparam int ENTRIES = 1 << IDX_W;

    localparam logic [1:0] C_CTR_SNT = 2'b00;
    localparam logic [1:0] C_CTR_WT  = 2'b10;
    localparam logic [1:0] C_CTR_ST  = 2'b11;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [DATA_W-1:0]  r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [15:0]        r_mp_count;

    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic              w_lk_hit;
    logic [IDX_W-1:0]  w_up_idx;
    logic [TAG_W-1:0]  w_up_tag;
    logic              w_up_hit;
    logic [DATA_W-1:0] w_seq_pc;
    logic [3:0]        w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = {lookup_pc[1:0], update_pc[1:0]};

    assign w_lk_idx = lookup_pc[IDX_W+1:2];
    assign w_lk_tag = lookup_pc[DATA_W-1:IDX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign w_up_idx = update_pc[IDX_W+1:2];
    assign w_up_tag = update_pc[DATA_W-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign w_seq_pc       = lookup_pc + DATA_W'(4);
    assign predict_taken  = w_lk_hit & r_ctr[w_lk_idx][1];
    assign predict_target = predict_taken ? r_target[w_lk_idx] : w_seq_pc;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= C_CTR_SNT;
            end
        end else if (update_en) begin
            if (w_up_hit) begin
                if (update_taken) begin
                    if (r_ctr[w_up_idx] != C_CTR_ST) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                    end
                    r_target[w_up_idx] <= update_target;
                end else if (r_ctr[w_up_idx] != C_CTR_SNT) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
                end
            end else if (update_taken) begin
                // Not-taken misses are never allocated; they would only predict fall-through.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= update_target;
                r_ctr[w_up_idx]    <= C_CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mp_count <= '0;
        end else if (update_en && mispredict && (r_mp_count != 16'hFFFF)) begin
            r_mp_count <= r_mp_count + 16'd1;
        end
    end

    assign mispredict_count = r_mp_count;

endmodule
`default_nettype wire
